// File: rtl/kpd_pkg.sv
// Shared types and default timing for the keypad event path.
// Pure declarations; no latency.
// No flow control here; consumers size their counters from these constants.
package kpd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } kpd_state_t;

    localparam int KEY_W = 4;

    // Defaults shared with the keypad scan/debounce driver
    localparam int KPD_DEPTH          = 4;
    localparam int KPD_INTR_CYCLES    = 3;
    localparam int KPD_HOLDOFF_CYCLES = 2;
    localparam int KPD_RETRY_CYCLES   = 1000000;

endpackage

// File: rtl/key_fifo.sv
// Key-code FIFO: storage, wrap-around pointers, occupancy and sticky overflow.
// Push/pop take effect at the clock edge; the head code is visible combinationally from the head register.
// A push into a full FIFO is accepted only if a pop happens in the same cycle; otherwise it is dropped and flagged.
module key_fifo
    import kpd_pkg::*;
#(
    parameter int DEPTH = KPD_DEPTH,
    parameter int KEY_W = kpd_pkg::KEY_W
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [KEY_W-1:0]         push_dat,
    input  logic                     pop_req,
    input  logic                     clr_ovf,
    output logic [KEY_W-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, push, pop, drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = pop_req && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push  = push_vld && (!full || pop);
    assign drop  = push_vld && full && !pop;

    // Occupancy and overflow next-state; a drop beats a same-cycle clear
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/keypad_event_ctrl.sv
// Queues key presses and sequences a fixed-width, re-armable interrupt pulse to the MCU.
// Key -> intr high in 2 cycles minimum; key_data/count follow the FIFO the cycle after a push or read.
// Keys arriving while the FIFO is full and not being read are dropped and flagged on overflow.
module keypad_event_ctrl
    import kpd_pkg::*;
#(
    parameter int DEPTH          = KPD_DEPTH,
    parameter int INTR_CYCLES    = KPD_INTR_CYCLES,
    parameter int HOLDOFF_CYCLES = KPD_HOLDOFF_CYCLES,
    parameter int RETRY_CYCLES   = KPD_RETRY_CYCLES
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     key_valid,
    input  logic [KEY_W-1:0]         key_code,
    input  logic                     rd_strobe,
    input  logic                     clr_ovf,
    output logic                     intr,
    output logic [KEY_W-1:0]         key_data,
    output logic                     key_avail,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state_dbg
);

    localparam int PCW = (INTR_CYCLES    > 1) ? $clog2(INTR_CYCLES)    : 1;
    localparam int HCW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int RCW = (RETRY_CYCLES   > 1) ? $clog2(RETRY_CYCLES)   : 1;

    kpd_state_t             state_q, state_d;
    logic [PCW-1:0]         pulse_q, pulse_d;
    logic [HCW-1:0]         hold_q, hold_d;
    logic [RCW-1:0]         retry_q, retry_d;
    logic                   intr_q, intr_d;
    logic [KEY_W-1:0]       head;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   fifo_ovf;
    logic                   pending;

    key_fifo #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (key_valid),
        .push_dat (key_code),
        .pop_req  (rd_strobe),
        .clr_ovf  (clr_ovf),
        .head_dat (head),
        .count    (fifo_cnt),
        .overflow (fifo_ovf)
    );

    assign pending = (fifo_cnt != '0);

    // Interrupt sequencer: intr_d is high exactly for the cycles spent in PULSE
    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        hold_d  = hold_q;
        retry_d = retry_q;
        intr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    state_d = PULSE;
                    pulse_d = PCW'(INTR_CYCLES - 1);
                    intr_d  = 1'b1;
                end
            end
            PULSE: begin
                // A read here pops the FIFO but the pulse still runs to full width
                if (pulse_q == '0) begin
                    state_d = WAIT;
                    retry_d = '0;
                end else begin
                    pulse_d = pulse_q - PCW'(1);
                    intr_d  = 1'b1;
                end
            end
            WAIT: begin
                if (rd_strobe) begin
                    state_d = HOLD;
                    hold_d  = HCW'(HOLDOFF_CYCLES - 1);
                end else if (!pending) begin
                    state_d = IDLE;
                end else if (retry_q == RCW'(RETRY_CYCLES - 1)) begin
                    // ISR never came: re-issue the pulse
                    state_d = PULSE;
                    pulse_d = PCW'(INTR_CYCLES - 1);
                    intr_d  = 1'b1;
                end else begin
                    retry_d = retry_q + RCW'(1);
                end
            end
            HOLD: begin
                // Guaranteed low gap so the MCU sees separate edges per key
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, counters and the registered interrupt output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pulse_q <= '0;
            hold_q  <= '0;
            retry_q <= '0;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            hold_q  <= hold_d;
            retry_q <= retry_d;
            intr_q  <= intr_d;
        end
    end

    assign intr      = intr_q;
    assign state_dbg = state_q;
    assign key_data  = head;
    assign key_avail = pending;
    assign overflow  = fifo_ovf;
    assign count     = fifo_cnt;

endmodule
